sdram_burst_copy_dma: RTL and testbench

//  Parametrised copy engine between the HPS f2h_sdram0 read-only port and the f2h_sdram1 write-only port.

---
 rtl/sdram_dma_pkg.sv | 17 +
 rtl/sdram_dma_fifo.sv | 47 ++++
 rtl/sdram_burst_copy_dma.sv | 207 ++++++++++++++++++++
 tb/tb_sdram_burst_copy_dma.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_dma_pkg.sv
// Shared types and helpers for the SDRAM burst copy DMA.
// The optional running checksum is enabled with `define SDRAM_DMA_CHECKSUM_EN.
package sdram_dma_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} top_state_t;
  typedef enum logic {RI, RREQ} rd_state_t;
  typedef enum logic {WI, WBURST} wr_state_t;

  // Wide enough for any practical DATA_W/8; the top slices what it needs.
  localparam logic [63:0] BYTE_EN_ALL = '1;

  // Burst length: whatever is left, capped at the maximum burst.
  function automatic logic [31:0] burst_min(input logic [31:0] left, input logic [31:0] bmax);
    return (left < bmax) ? left : bmax;
  endfunction

endpackage

// File: rtl/sdram_dma_fifo.sv
// Show-ahead staging FIFO: head is the oldest word, valid whenever count != 0.
// Read is asynchronous so the write port sees data in the same cycle it pops.
module sdram_dma_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;

  // Storage array; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/sdram_burst_copy_dma.sv
// Burst copy engine: reads LEN words from SRC on one Avalon-MM port and writes
// them to DST on another, staging through a FIFO. Read and write engines run
// concurrently; reads are only issued when the FIFO can absorb the whole burst.
// Optional: `define SDRAM_DMA_CHECKSUM_EN adds a running sum of written words.
module sdram_burst_copy_dma
  import sdram_dma_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 30,
  parameter int BURST_W    = 8,
  parameter int BURST_MAX  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W      = 24
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   rd_address,
  output logic [BURST_W-1:0]  rd_burstcount,
  output logic                rd_read,
  input  logic                rd_waitrequest,
  input  logic [DATA_W-1:0]   rd_readdata,
  input  logic                rd_readdatavalid,
  output logic [ADDR_W-1:0]   wr_address,
  output logic [BURST_W-1:0]  wr_burstcount,
  output logic                wr_write,
  output logic [DATA_W-1:0]   wr_writedata,
  output logic [DATA_W/8-1:0] wr_byteenable,
  input  logic                wr_waitrequest
`ifdef SDRAM_DMA_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  top_state_t top_state, top_next;
  rd_state_t  rd_state, rd_next;
  wr_state_t  wr_state, wr_next;

  logic [ADDR_W-1:0]  rd_addr_reg, wr_addr_reg;       // address of the next burst
  logic [LEN_W-1:0]   rd_left_reg, wr_left_reg;       // words not yet requested / written
  logic [CNT_W-1:0]   rd_pending_reg;                 // requested beats not yet returned
  logic [BURST_W-1:0] wr_beats_reg;                   // beats left in current write burst
  logic [ADDR_W-1:0]  rd_address_reg, wr_address_reg;
  logic [BURST_W-1:0] rd_burstcount_reg, wr_burstcount_reg;
  logic               done_reg;

  logic               start_ok, rd_accept, wr_accept, wr_last, rd_issue, wr_issue;
  logic [LEN_W-1:0]   issue_left;
  logic [ADDR_W-1:0]  issue_addr;
  logic [BURST_W-1:0] rd_size, wr_size;
  logic [CNT_W-1:0]   fifo_count;
  logic [DATA_W-1:0]  fifo_head;

  assign start_ok  = (top_state == IDLE) && start;
  assign rd_read   = (rd_state == RREQ);
  assign wr_write  = (wr_state == WBURST);
  assign rd_accept = rd_read && !rd_waitrequest;
  assign wr_accept = wr_write && !wr_waitrequest;
  assign wr_last   = wr_accept && (wr_left_reg == LEN_W'(1));
  assign busy      = (top_state == RUN);
  assign done      = done_reg;

  // The first read burst is issued straight from the start inputs so the
  // request appears one cycle after start.
  assign issue_left = start_ok ? len : rd_left_reg;
  assign issue_addr = start_ok ? src_addr : rd_addr_reg;
  assign rd_size    = BURST_W'(burst_min(32'(issue_left), BURST_MAX));
  assign wr_size    = BURST_W'(burst_min(32'(wr_left_reg), BURST_MAX));
  assign rd_issue   = (rd_state == RI) && (start_ok || top_state == RUN) && (issue_left != '0)
                   && (32'(fifo_count) + 32'(rd_pending_reg) + 32'(rd_size) <= 32'(FIFO_DEPTH));
  assign wr_issue   = (wr_state == WI) && (top_state == RUN) && (wr_left_reg != '0)
                   && (32'(fifo_count) >= 32'(wr_size));

  assign rd_address    = rd_address_reg;
  assign rd_burstcount = rd_burstcount_reg;
  assign wr_address    = wr_address_reg;
  assign wr_burstcount = wr_burstcount_reg;
  assign wr_writedata  = wr_write ? fifo_head : '0;
  assign wr_byteenable = BYTE_EN_ALL[DATA_W/8-1:0];

  sdram_dma_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (rd_readdatavalid),
    .push_data (rd_readdata),
    .pop       (wr_accept),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // State registers for the top, read and write FSMs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      top_state <= IDLE;
      rd_state  <= RI;
      wr_state  <= WI;
    end else begin
      top_state <= top_next;
      rd_state  <= rd_next;
      wr_state  <= wr_next;
    end
  end

  // Next-state logic for all three FSMs.
  always_comb begin
    top_next = top_state;
    rd_next  = rd_state;
    wr_next  = wr_state;
    case (top_state)
      IDLE:    if (start) top_next = (len == '0) ? DONE : RUN;
      RUN:     if (wr_last) top_next = DONE;
      DONE:    top_next = IDLE;
      default: top_next = IDLE;
    endcase
    case (rd_state)
      RI:      if (rd_issue) rd_next = RREQ;
      RREQ:    if (rd_accept) rd_next = RI;
      default: rd_next = RI;
    endcase
    case (wr_state)
      WI:      if (wr_issue) wr_next = WBURST;
      WBURST:  if (wr_accept && wr_beats_reg == BURST_W'(1)) wr_next = WI;
      default: wr_next = WI;
    endcase
  end

  // Read engine datapath: burst header, next address, words left, beats in flight.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_addr_reg       <= '0;
      rd_left_reg       <= '0;
      rd_pending_reg    <= '0;
      rd_address_reg    <= '0;
      rd_burstcount_reg <= '0;
    end else begin
      if (start_ok) begin
        rd_addr_reg <= src_addr;
        rd_left_reg <= len;
      end
      if (rd_issue) begin
        rd_address_reg    <= issue_addr;
        rd_burstcount_reg <= rd_size;
      end
      if (rd_accept) begin
        rd_addr_reg <= rd_address_reg + ADDR_W'(rd_burstcount_reg);
        rd_left_reg <= rd_left_reg - LEN_W'(rd_burstcount_reg);
      end
      rd_pending_reg <= rd_pending_reg
                      + (rd_accept ? CNT_W'(rd_burstcount_reg) : CNT_W'(0))
                      - (rd_readdatavalid ? CNT_W'(1) : CNT_W'(0));
    end
  end

  // Write engine datapath: header held for the whole burst, address advances at burst end.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_addr_reg       <= '0;
      wr_left_reg       <= '0;
      wr_beats_reg      <= '0;
      wr_address_reg    <= '0;
      wr_burstcount_reg <= '0;
    end else begin
      if (start_ok) begin
        wr_addr_reg <= dst_addr;
        wr_left_reg <= len;
      end
      if (wr_issue) begin
        wr_address_reg    <= wr_addr_reg;
        wr_burstcount_reg <= wr_size;
        wr_beats_reg      <= wr_size;
      end
      if (wr_accept) begin
        wr_beats_reg <= wr_beats_reg - BURST_W'(1);
        wr_left_reg  <= wr_left_reg - LEN_W'(1);
        if (wr_beats_reg == BURST_W'(1))
          wr_addr_reg <= wr_address_reg + ADDR_W'(wr_burstcount_reg);
      end
    end
  end

  // Completion pulse, one cycle after the FSM passes through DONE.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) done_reg <= 1'b0;
    else                done_reg <= (top_state == DONE);
  end

`ifdef SDRAM_DMA_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_reg;

  // Running sum of accepted write beats, cleared by an accepted start.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  checksum_reg <= '0;
    else if (start_ok)   checksum_reg <= '0;
    else if (wr_accept)  checksum_reg <= checksum_reg + wr_writedata;
  end

  assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_sdram_burst_copy_dma.sv
// Directed bench for sdram_burst_copy_dma: table of copy jobs plus hand-written
// sequences for len==0 timing and reset mid-transfer.
module tb_sdram_burst_copy_dma;

  logic        clk;
  logic        reset_reset_n;
  logic        start;
  logic [29:0] src_addr, dst_addr;
  logic [23:0] len;
  logic        busy, done;
  logic [29:0] rd_address, wr_address;
  logic [7:0]  rd_burstcount, wr_burstcount;
  logic        rd_read, rd_waitrequest, rd_readdatavalid;
  logic [31:0] rd_readdata;
  logic        wr_write, wr_waitrequest;
  logic [31:0] wr_writedata;
  logic [3:0]  wr_byteenable;
`ifdef SDRAM_DMA_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  sdram_burst_copy_dma dut (
    .clk_clk          (clk),
    .reset_reset_n    (reset_reset_n),
    .start            (start),
    .src_addr         (src_addr),
    .dst_addr         (dst_addr),
    .len              (len),
    .busy             (busy),
    .done             (done),
    .rd_address       (rd_address),
    .rd_burstcount    (rd_burstcount),
    .rd_read          (rd_read),
    .rd_waitrequest   (rd_waitrequest),
    .rd_readdata      (rd_readdata),
    .rd_readdatavalid (rd_readdatavalid),
    .wr_address       (wr_address),
    .wr_burstcount    (wr_burstcount),
    .wr_write         (wr_write),
    .wr_writedata     (wr_writedata),
    .wr_byteenable    (wr_byteenable),
    .wr_waitrequest   (wr_waitrequest)
`ifdef SDRAM_DMA_CHECKSUM_EN
    ,
    .checksum         (checksum)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          len;
    logic [29:0] src;
    logic [29:0] dst;
    int          mode;       // 0 no stalls, 1 random stalls/gaps, 2 write port held 200 cycles
    int          nb;         // expected bursts on each port
    int          first_cnt;
    int          last_cnt;
    logic [29:0] last_rd;
    logic [29:0] last_wr;
  } vec_t;

  vec_t vecs[9];

  int checks = 0;
  int errors = 0;

  // Slave/scoreboard state shared by driver, monitor and test sequences.
  int          mode = 0;
  int          hold_cnt = 0;
  logic [31:0] ret_q[$];
  logic [29:0] rb_addr[$], wb_addr[$];
  int          rb_cnt[$], wb_cnt[$];
  logic [31:0] wmem [logic [29:0]];
  int          acc_words, wr_words, max_occ, done_cnt, beat_idx;
  logic        busy_seen;
  logic [31:0] wsum;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] src_word(input logic [29:0] a);
    return {a[15:0], a[29:14]} ^ 32'hC3A5_5A3C;
  endfunction

  // Slave driver: updates bus inputs just after each rising edge.
  initial begin
    rd_waitrequest = 1'b0; rd_readdatavalid = 1'b0; rd_readdata = '0; wr_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rd_waitrequest = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (hold_cnt > 0) begin
        wr_waitrequest = 1'b1;
        hold_cnt--;
      end else begin
        wr_waitrequest = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (reset_reset_n && ret_q.size() > 0 && (mode != 1 || $urandom_range(0, 1) == 1)) begin
        rd_readdatavalid = 1'b1;
        rd_readdata = ret_q.pop_front();
      end else begin
        rd_readdatavalid = 1'b0;
        rd_readdata = '0;
      end
    end
  end

  // Bus monitor on the falling edge: records bursts, checks hold rules, tracks occupancy.
  initial begin
    logic        rd_stall_prev, wr_stall_prev;
    logic [29:0] prev_rd_addr, prev_wr_addr, a, cur_addr;
    logic [7:0]  prev_rd_cnt, prev_wr_cnt;
    logic [31:0] prev_wr_data;
    int          cur_cnt;
    rd_stall_prev = 1'b0; wr_stall_prev = 1'b0; cur_cnt = 0; cur_addr = '0;
    prev_rd_addr = '0; prev_wr_addr = '0; prev_rd_cnt = '0; prev_wr_cnt = '0; prev_wr_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_reset_n) begin
        rd_stall_prev = 1'b0;
        wr_stall_prev = 1'b0;
      end else begin
        if (rd_stall_prev)
          check("rd_hold", {rd_read, rd_address, rd_burstcount}, {1'b1, prev_rd_addr, prev_rd_cnt});
        rd_stall_prev = rd_read && rd_waitrequest;
        prev_rd_addr = rd_address;
        prev_rd_cnt = rd_burstcount;
        if (rd_read && !rd_waitrequest) begin
          rb_addr.push_back(rd_address);
          rb_cnt.push_back(int'(rd_burstcount));
          for (int i = 0; i < int'(rd_burstcount); i++) begin
            a = rd_address + 30'(i);
            ret_q.push_back(src_word(a));
          end
          acc_words += int'(rd_burstcount);
        end
        if (beat_idx != 0) check("wr_continuous", wr_write, 1);
        if (wr_stall_prev) check("wr_hold", {wr_write, wr_writedata}, {1'b1, prev_wr_data});
        if (wr_stall_prev && beat_idx == 0)
          check("wr_hdr_hold", {wr_address, wr_burstcount}, {prev_wr_addr, prev_wr_cnt});
        wr_stall_prev = wr_write && wr_waitrequest;
        prev_wr_addr = wr_address;
        prev_wr_cnt = wr_burstcount;
        prev_wr_data = wr_writedata;
        if (wr_write && !wr_waitrequest) begin
          if (beat_idx == 0) begin
            cur_addr = wr_address;
            cur_cnt = int'(wr_burstcount);
            wb_addr.push_back(wr_address);
            wb_cnt.push_back(cur_cnt);
          end
          a = cur_addr + 30'(beat_idx);
          wmem[a] = wr_writedata;
          wsum += wr_writedata;
          wr_words++;
          beat_idx++;
          if (beat_idx >= cur_cnt) beat_idx = 0;
        end
        if (acc_words - wr_words > max_occ) max_occ = acc_words - wr_words;
        if (done) done_cnt++;
        if (busy) busy_seen = 1'b1;
      end
    end
  end

  task automatic clear_board();
    rb_addr.delete(); rb_cnt.delete(); wb_addr.delete(); wb_cnt.delete(); wmem.delete();
    acc_words = 0; wr_words = 0; max_occ = 0; done_cnt = 0; beat_idx = 0;
    busy_seen = 1'b0; wsum = '0;
  endtask

  task automatic run_test(input int id, input vec_t v);
    int          cyc, bad;
    logic [29:0] a, d;
    logic [31:0] exp_sum;
    clear_board();
    mode = v.mode;
    hold_cnt = (v.mode == 2) ? 200 : 0;
    src_addr = v.src; dst_addr = v.dst; len = 24'(v.len);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("rd_latency", rd_read, v.len != 0);
    check("busy_on_start", busy, v.len != 0);
    if (v.len == 0) begin
      check("done_early", done, 0);
      @(negedge clk);
      check("done_2cyc", done, 1);
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout", cyc < 20000, 1);
    repeat (4) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("busy_seen", busy_seen, v.len != 0);
    check("rd_bursts", rb_addr.size(), v.nb);
    check("wr_bursts", wb_addr.size(), v.nb);
    if (v.nb > 0 && rb_addr.size() > 0 && wb_addr.size() > 0) begin
      check("rd_first_addr", rb_addr[0], v.src);
      check("wr_first_addr", wb_addr[0], v.dst);
      check("rd_first_cnt", rb_cnt[0], v.first_cnt);
      check("wr_first_cnt", wb_cnt[0], v.first_cnt);
      check("rd_last_cnt", rb_cnt[$], v.last_cnt);
      check("wr_last_cnt", wb_cnt[$], v.last_cnt);
      check("rd_last_addr", rb_addr[$], v.last_rd);
      check("wr_last_addr", wb_addr[$], v.last_wr);
    end
    check("wr_words", wr_words, v.len);
    bad = 0;
    exp_sum = '0;
    for (int i = 0; i < v.len; i++) begin
      a = v.src + 30'(i);
      d = v.dst + 30'(i);
      exp_sum += src_word(a);
      if (!wmem.exists(d)) bad++;
      else if (wmem[d] !== src_word(a)) bad++;
    end
    check("data_bad_words", bad, 0);
    check("occupancy_le_64", max_occ <= 64, 1);
`ifdef SDRAM_DMA_CHECKSUM_EN
    check("checksum", checksum, exp_sum);
`endif
    $display("job %0d: len=%0d src=%0h dst=%0h mode=%0d cycles=%0d rd_bursts=%0d wr_bursts=%0d max_occ=%0d sum=%0h",
             id, v.len, v.src, v.dst, v.mode, cyc, rb_addr.size(), wb_addr.size(), max_occ, exp_sum);
  endtask

  initial begin
    vecs[0] = '{len:32,  src:30'h100,      dst:30'h2000,     mode:0, nb:2,  first_cnt:16, last_cnt:16, last_rd:30'h110,  last_wr:30'h2010};
    vecs[1] = '{len:21,  src:30'h40,       dst:30'h800,      mode:0, nb:2,  first_cnt:16, last_cnt:5,  last_rd:30'h50,   last_wr:30'h810};
    vecs[2] = '{len:0,   src:30'h10,       dst:30'h20,       mode:0, nb:0,  first_cnt:0,  last_cnt:0,  last_rd:30'h0,    last_wr:30'h0};
    vecs[3] = '{len:1,   src:30'h7,        dst:30'h9,        mode:0, nb:1,  first_cnt:1,  last_cnt:1,  last_rd:30'h7,    last_wr:30'h9};
    vecs[4] = '{len:16,  src:30'h300,      dst:30'h400,      mode:0, nb:1,  first_cnt:16, last_cnt:16, last_rd:30'h300,  last_wr:30'h400};
    vecs[5] = '{len:17,  src:30'h500,      dst:30'h600,      mode:0, nb:2,  first_cnt:16, last_cnt:1,  last_rd:30'h510,  last_wr:30'h610};
    vecs[6] = '{len:50,  src:30'h1000,     dst:30'h3000,     mode:1, nb:4,  first_cnt:16, last_cnt:2,  last_rd:30'h1030, last_wr:30'h3030};
    vecs[7] = '{len:256, src:30'h4000,     dst:30'h8000,     mode:2, nb:16, first_cnt:16, last_cnt:16, last_rd:30'h40F0, last_wr:30'h80F0};
    vecs[8] = '{len:21,  src:30'h3FFFFFFB, dst:30'h3FFFFFF0, mode:1, nb:2,  first_cnt:16, last_cnt:5,  last_rd:30'h000000B, last_wr:30'h0};

    start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    clear_board();
    reset_reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", {busy, done, rd_read, wr_write, rd_burstcount, wr_burstcount}, 0);
    check("reset_addr", {rd_address, wr_address}, 0);
    check("reset_wdata", wr_writedata, 0);
    check("reset_byteen", wr_byteenable, 4'hF);
    @(posedge clk); #1 reset_reset_n = 1'b1;

    for (int k = 0; k < 9; k++) run_test(k, vecs[k]);

    // Start ignored while busy: a second start mid-job must not restart it.
    clear_board();
    mode = 0;
    src_addr = 30'h100; dst_addr = 30'h2000; len = 24'd32;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 src_addr = 30'h900; len = 24'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (60) @(negedge clk);
    check("busy_start_ignored_bursts", rb_addr.size(), 2);
    check("busy_start_ignored_words", wr_words, 32);
    check("busy_start_ignored_done", done_cnt, 1);
    $display("job busy-start: rd_bursts=%0d wr_words=%0d done=%0d", rb_addr.size(), wr_words, done_cnt);

    // Reset in the middle of a copy aborts with no completion pulse.
    clear_board();
    mode = 0;
    src_addr = 30'h100; dst_addr = 30'h2000; len = 24'd32;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #3 reset_reset_n = 1'b0;
    #1;
    check("abort_ctl", {busy, done, rd_read, wr_write, rd_burstcount, wr_burstcount}, 0);
    check("abort_addr", {rd_address, wr_address}, 0);
    check("abort_wdata", wr_writedata, 0);
    check("abort_byteen", wr_byteenable, 4'hF);
`ifdef SDRAM_DMA_CHECKSUM_EN
    check("abort_checksum", checksum, 0);
`endif
    ret_q.delete();
    repeat (3) @(posedge clk);
    check("abort_no_done", done_cnt, 0);
    $display("job abort: wr_words_before_reset=%0d done=%0d", wr_words, done_cnt);
    ret_q.delete();
    #2 reset_reset_n = 1'b1;
    run_test(9, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
